// File: rtl/fir_distb_pkg.sv
// Shared constants for the DA FIR coefficient-table loader: FSM encoding,
// register map and the default coefficient set with its prebuilt 16-entry table.
package fir_distb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BUILD     = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } fsm_state_e;

   localparam logic [2:0] ADDR_COEF0 = 3'd0;
   localparam logic [2:0] ADDR_COEF1 = 3'd1;
   localparam logic [2:0] ADDR_COEF2 = 3'd2;
   localparam logic [2:0] ADDR_COEF3 = 3'd3;
   localparam logic [2:0] ADDR_CTRL  = 3'd4;

   localparam int DEF_COEF [4] = '{41, 132, 341, 510};

   // entry k = sum of DEF_COEF[i] for each set bit i of k
   localparam int DEF_TBL [16] = '{
        0,   41,  132,  173,
      341,  382,  473,  514,
      510,  551,  642,  683,
      851,  892,  983, 1024
   };

endpackage

// File: rtl/fir_distb_tbl_bank.sv
// One 16-entry DA table bank: single write port, combinational read,
// asynchronous reset either to zeros or to the default table.
module fir_distb_tbl_bank
   import fir_distb_pkg::*;
#(
   parameter int TBL_WIDTH   = 12,
   parameter bit RST_DEFAULT = 1'b0
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 wr_en,
   input  logic [3:0]           wr_addr,
   input  logic [TBL_WIDTH-1:0] wr_data,
   input  logic [3:0]           rd_addr,
   output logic [TBL_WIDTH-1:0] rd_data
);

   logic [TBL_WIDTH-1:0] mem_q [16];
   logic [TBL_WIDTH-1:0] mem_d [16];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= RST_DEFAULT ? TBL_WIDTH'(DEF_TBL[i]) : '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fir_distb_tbl_loader.sv
// DA FIR coefficient-table loader: builds a saturated partial-sum table into the
// shadow bank and swaps it in at a frame boundary. Optional: FIR_DISTB_TBL_DEFAULT_EN.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for start; staging regs writable
// ST_BUILD     | writing shadow entry cnt_q (0..15), one per cycle
// ST_WAIT_SWAP | shadow complete; swap banks on the next frame_pulse
module fir_distb_tbl_loader
   import fir_distb_pkg::*;
#(
   parameter int COEF_WIDTH = 12,
   parameter int TBL_WIDTH  = 12,
   parameter int NCOEF      = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 icb_wr,
   input  logic [2:0]           icb_addr,
   input  logic [15:0]          icb_wdat,
   input  logic                 frame_pulse,
   input  logic [3:0]           tbl_rd_addr,
   output logic [TBL_WIDTH-1:0] tbl_rd_data,
   output logic                 busy,
   output logic                 tbl_valid,
   output logic                 sat_err
);

`ifdef FIR_DISTB_TBL_DEFAULT_EN
   localparam bit RST_DEFAULT = 1'b1;
`else
   localparam bit RST_DEFAULT = 1'b0;
`endif

   localparam int SUM_W = COEF_WIDTH + 2;
   localparam int CMP_W = ((SUM_W > TBL_WIDTH) ? SUM_W : TBL_WIDTH) + 1;
   localparam logic signed [CMP_W-1:0] TBL_MAX = CMP_W'((64'sd1 <<< (TBL_WIDTH - 1)) - 64'sd1);
   localparam logic signed [CMP_W-1:0] TBL_MIN = -TBL_MAX - CMP_W'(1);

   fsm_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic signed [COEF_WIDTH-1:0] stg_q [NCOEF];
   logic signed [COEF_WIDTH-1:0] stg_d [NCOEF];
   logic signed [COEF_WIDTH-1:0] work_q [NCOEF];
   logic signed [COEF_WIDTH-1:0] work_d [NCOEF];
   logic bank_sel_q, bank_sel_d;
   logic tbl_valid_q, tbl_valid_d;
   logic sat_err_q, sat_err_d;

   logic                        start_req;
   logic                        shadow_we;
   logic signed [SUM_W-1:0]     sum;
   logic signed [CMP_W-1:0]     sum_ext;
   logic [TBL_WIDTH-1:0]        entry;
   logic                        entry_sat;
   logic [TBL_WIDTH-1:0]        rd_data0, rd_data1;
   logic                        unused_wdat;

   assign unused_wdat = ^icb_wdat;
   assign start_req   = icb_wr && (icb_addr == ADDR_CTRL) && icb_wdat[0];

   always_comb begin
      sum = '0;
      for (int i = 0; i < NCOEF; i++) begin
         if (cnt_q[i]) begin
            sum = sum + SUM_W'(work_q[i]);
         end
      end
      sum_ext   = CMP_W'(sum);
      entry_sat = 1'b0;
      entry     = sum_ext[TBL_WIDTH-1:0];
      if (sum_ext > TBL_MAX) begin
         entry     = TBL_MAX[TBL_WIDTH-1:0];
         entry_sat = 1'b1;
      end else if (sum_ext < TBL_MIN) begin
         entry     = TBL_MIN[TBL_WIDTH-1:0];
         entry_sat = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stg_d       = stg_q;
      work_d      = work_q;
      bank_sel_d  = bank_sel_q;
      tbl_valid_d = tbl_valid_q;
      sat_err_d   = sat_err_q;
      shadow_we   = 1'b0;

      if (icb_wr && !icb_addr[2]) begin
         stg_d[icb_addr[1:0]] = icb_wdat[COEF_WIDTH-1:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               // snapshot uses stg_q, so a same-cycle coef write lands in the next build
               work_d    = stg_q;
               sat_err_d = 1'b0;
               cnt_d     = 4'd0;
               state_d   = ST_BUILD;
            end
         end
         ST_BUILD: begin
            shadow_we = 1'b1;
            if (entry_sat) begin
               sat_err_d = 1'b1;
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'hF) begin
               state_d = ST_WAIT_SWAP;
            end
         end
         ST_WAIT_SWAP: begin
            if (frame_pulse) begin
               bank_sel_d  = ~bank_sel_q;
               tbl_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         bank_sel_q  <= 1'b0;
         tbl_valid_q <= RST_DEFAULT;
         sat_err_q   <= 1'b0;
         for (int i = 0; i < NCOEF; i++) begin
            stg_q[i]  <= COEF_WIDTH'(DEF_COEF[i]);
            work_q[i] <= COEF_WIDTH'(DEF_COEF[i]);
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bank_sel_q  <= bank_sel_d;
         tbl_valid_q <= tbl_valid_d;
         sat_err_q   <= sat_err_d;
         stg_q       <= stg_d;
         work_q      <= work_d;
      end
   end

   // the shadow is always the bank not currently selected
   fir_distb_tbl_bank #(
      .TBL_WIDTH   (TBL_WIDTH),
      .RST_DEFAULT (RST_DEFAULT)
   ) u_bank0 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_en   (shadow_we && bank_sel_q),
      .wr_addr (cnt_q),
      .wr_data (entry),
      .rd_addr (tbl_rd_addr),
      .rd_data (rd_data0)
   );

   fir_distb_tbl_bank #(
      .TBL_WIDTH   (TBL_WIDTH),
      .RST_DEFAULT (RST_DEFAULT)
   ) u_bank1 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_en   (shadow_we && !bank_sel_q),
      .wr_addr (cnt_q),
      .wr_data (entry),
      .rd_addr (tbl_rd_addr),
      .rd_data (rd_data1)
   );

   assign tbl_rd_data = bank_sel_q ? rd_data1 : rd_data0;
   assign busy        = (state_q != ST_IDLE);
   assign tbl_valid   = tbl_valid_q;
   assign sat_err     = sat_err_q;

endmodule

// File: tb/tb_fir_distb_tbl_loader.sv
// Directed bench for fir_distb_tbl_loader with hand-computed table entries.
module tb_fir_distb_tbl_loader;

`ifdef FIR_DISTB_TBL_DEFAULT_EN
   localparam int DEF15 = 1024;
   localparam int DEF5  = 382;
   localparam int DEFV  = 1;
`else
   localparam int DEF15 = 0;
   localparam int DEF5  = 0;
   localparam int DEFV  = 0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        icb_wr = 1'b0;
   logic [2:0]  icb_addr = '0;
   logic [15:0] icb_wdat = '0;
   logic        frame_pulse = 1'b0;
   logic [3:0]  tbl_rd_addr = '0;
   logic [11:0] tbl_rd_data;
   logic        busy, tbl_valid, sat_err;

   int checks = 0;
   int failures = 0;

   fir_distb_tbl_loader dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .icb_wr      (icb_wr),
      .icb_addr    (icb_addr),
      .icb_wdat    (icb_wdat),
      .frame_pulse (frame_pulse),
      .tbl_rd_addr (tbl_rd_addr),
      .tbl_rd_data (tbl_rd_data),
      .busy        (busy),
      .tbl_valid   (tbl_valid),
      .sat_err     (sat_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic wr(input int addr, input int data);
      icb_wr   = 1'b1;
      icb_addr = 3'(addr);
      icb_wdat = 16'(data);
      tick();
      icb_wr   = 1'b0;
   endtask

   task automatic rd(input int addr, output int val);
      tbl_rd_addr = 4'(addr);
      #1;
      val = int'($signed(tbl_rd_data));
   endtask

   task automatic set_coefs(input int a, input int b, input int c, input int d);
      wr(0, a); wr(1, b); wr(2, c); wr(3, d);
   endtask

   // start, then pulse frame_pulse in cycle t+pulse_at; returns in cycle t+pulse_at+1
   task automatic build_swap(input int pulse_at);
      wr(4, 1);
      for (int c = 1; c <= pulse_at; c++) begin
         if (c == pulse_at) frame_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0;
      end
   endtask

   initial begin
      int v;

      // reset state
      tick(); tick();
      sys_rst = 1'b0;
      tick();
      rd(15, v); chk("rst_e15", v, DEF15);
      rd(5, v);  chk("rst_e5", v, DEF5);
      rd(0, v);  chk("rst_e0", v, 0);
      chk("rst_valid", int'(tbl_valid), DEFV);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sat", int'(sat_err), 0);

      // 1,2,4,8: old table must stay visible until the pulse at t+20
      set_coefs(1, 2, 4, 8);
      wr(4, 1);
      for (int c = 1; c <= 20; c++) begin
         chk($sformatf("b1_busy_t%0d", c), int'(busy), 1);
         rd(15, v);
         chk($sformatf("b1_old_t%0d", c), v, DEF15);
         if (c == 20) frame_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0;
      end
      chk("b1_busy_after", int'(busy), 0);
      chk("b1_valid", int'(tbl_valid), 1);
      rd(15, v); chk("b1_e15", v, 15);
      rd(7, v);  chk("b1_e7", v, 7);
      rd(10, v); chk("b1_e10", v, 10);
      rd(0, v);  chk("b1_e0", v, 0);
      chk("b1_sat", int'(sat_err), 0);

      // pulses at t+5 and t+16 ignored; swap at t+17
      set_coefs(3, 5, 7, 11);
      wr(4, 1);
      for (int c = 1; c <= 17; c++) begin
         if (c == 5 || c == 16 || c == 17) frame_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0;
         if (c == 16) begin
            rd(15, v); chk("fp_early_e15", v, 15);
            chk("fp_early_busy", int'(busy), 1);
         end
      end
      chk("fp_busy", int'(busy), 0);
      rd(15, v); chk("fp_e15", v, 26);
      rd(6, v);  chk("fp_e6", v, 12);

      // start and coef write during BUILD
      set_coefs(10, 20, 30, 40);
      wr(4, 1);
      tick(); tick();
      wr(0, 100);
      wr(4, 1);
      for (int c = 5; c <= 17; c++) begin
         if (c == 17) frame_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0;
      end
      chk("mid_busy", int'(busy), 0);
      rd(1, v);  chk("mid_e1", v, 10);
      rd(15, v); chk("mid_e15", v, 100);
      build_swap(17);
      rd(1, v);  chk("next_e1", v, 100);
      rd(15, v); chk("next_e15", v, 190);

      // saturation
      set_coefs(2047, 2047, 2047, 2047);
      build_swap(17);
      chk("satp_flag", int'(sat_err), 1);
      rd(3, v);  chk("satp_e3", v, 2047);
      rd(1, v);  chk("satp_e1", v, 2047);
      rd(15, v); chk("satp_e15", v, 2047);
      set_coefs('h800, 'h800, 'h800, 'h800);
      wr(4, 1);
      chk("satn_clear", int'(sat_err), 0);
      for (int c = 1; c <= 17; c++) begin
         if (c == 17) frame_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0;
      end
      chk("satn_flag", int'(sat_err), 1);
      rd(15, v); chk("satn_e15", v, -2048);
      rd(1, v);  chk("satn_e1", v, -2048);
      set_coefs(1, 2, 4, 8);
      build_swap(17);
      chk("sat_cleared", int'(sat_err), 0);
      rd(9, v);  chk("sat_e9", v, 9);

      // reset mid-build at t+8
      set_coefs(5, 6, 7, 9);
      wr(4, 1);
      for (int c = 1; c < 8; c++) tick();
      chk("mrst_busy_pre", int'(busy), 1);
      sys_rst = 1'b1;
      #1;
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_sat", int'(sat_err), 0);
      chk("mrst_valid", int'(tbl_valid), DEFV);
      rd(15, v); chk("mrst_e15", v, DEF15);
      rd(5, v);  chk("mrst_e5", v, DEF5);
      tick();
      sys_rst = 1'b0;
      tick();
      build_swap(18);
      chk("mrst_busy_after", int'(busy), 0);
      chk("mrst_valid_after", int'(tbl_valid), 1);
      rd(15, v); chk("mrst_new_e15", v, 1024);
      rd(5, v);  chk("mrst_new_e5", v, 382);
      rd(12, v); chk("mrst_new_e12", v, 851);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
